// File: rtl/word_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in over valid/ready, one bit per
// clock out MSB first with first/last strobes, plus a one-word holding register.
module word_serializer #(
  parameter int WIDTH = 8,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_bit,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy,
  output logic [7:0]       words_sent
);

  localparam int              CW        = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   CNT_LAST  = CW'(WIDTH - 1);
  localparam logic [CW-1:0]   CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
  localparam logic [3:0]      GCNT_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
  localparam bit              HAS_GAP   = (GAP > 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] shreg_r;
  logic [CW-1:0]    cnt_r;
  logic [3:0]       gcnt_r;
  logic [WIDTH-1:0] hold_r;
  logic             hold_full_r;
  logic [7:0]       words_sent_r;
  logic             ser_bit_r;
  logic             ser_valid_r;
  logic             ser_first_r;
  logic             ser_last_r;
  logic             busy_r;

  state_t           state_s;
  logic [WIDTH-1:0] shreg_s;
  logic [CW-1:0]    cnt_s;
  logic [3:0]       gcnt_s;
  logic [WIDTH-1:0] hold_s;
  logic             hold_full_s;
  logic [7:0]       words_sent_s;
  logic             accept_s;
  logic             last_bit_s;
  logic             word_end_s;
  logic             ser_bit_s;
  logic             ser_valid_s;
  logic             ser_first_s;
  logic             ser_last_s;
  logic             busy_s;

  // Ready depends only on the holding register so it never waits on in_valid.
  assign in_ready = rst_n & ~hold_full_r;

  // Next-state and datapath: shifting, gap counting, hold fill/drain and bypass.
  always_comb begin
    state_s      = state_r;
    shreg_s      = shreg_r;
    cnt_s        = cnt_r;
    gcnt_s       = gcnt_r;
    hold_s       = hold_r;
    hold_full_s  = hold_full_r;
    words_sent_s = words_sent_r;

    accept_s   = in_valid & in_ready;
    last_bit_s = (state_r == ST_SHIFT) && (cnt_r == CNT_LAST);
    if (HAS_GAP) begin
      word_end_s = (state_r == ST_GAP) && (gcnt_r == GCNT_LAST);
    end else begin
      word_end_s = last_bit_s;
    end

    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          shreg_s = in_data;
          cnt_s   = CNT_ZERO;
          state_s = ST_SHIFT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        shreg_s = {shreg_r[WIDTH-2:0], 1'b0};
        if (last_bit_s) begin
          cnt_s        = CNT_ZERO;
          words_sent_s = words_sent_r + 8'd1;
          if (HAS_GAP) begin
            state_s = ST_GAP;
            gcnt_s  = 4'd0;
          end else begin
            state_s = ST_SHIFT;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_GAP: begin
        gcnt_s = gcnt_r + 4'd1;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // Word end overrides the plain shift/gap update: drain hold, bypass, or go idle.
    if (word_end_s) begin
      if (hold_full_r) begin
        shreg_s     = hold_r;
        hold_full_s = 1'b0;
        cnt_s       = CNT_ZERO;
        state_s     = ST_SHIFT;
      end else if (accept_s) begin
        shreg_s = in_data;
        cnt_s   = CNT_ZERO;
        state_s = ST_SHIFT;
      end else begin
        state_s = ST_IDLE;
      end
    end else if (accept_s && (state_r != ST_IDLE)) begin
      hold_s      = in_data;
      hold_full_s = 1'b1;
    end else begin
      hold_full_s = hold_full_s;
    end

    ser_valid_s = (state_s == ST_SHIFT);
    if (ser_valid_s) begin
      ser_bit_s   = shreg_s[WIDTH-1];
      ser_first_s = (cnt_s == CNT_ZERO);
      ser_last_s  = (cnt_s == CNT_LAST);
    end else begin
      ser_bit_s   = 1'b0;
      ser_first_s = 1'b0;
      ser_last_s  = 1'b0;
    end
    busy_s = (state_s != ST_IDLE) | hold_full_s;
  end

  // State and registered outputs, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      shreg_r      <= {WIDTH{1'b0}};
      cnt_r        <= CNT_ZERO;
      gcnt_r       <= 4'd0;
      hold_r       <= {WIDTH{1'b0}};
      hold_full_r  <= 1'b0;
      words_sent_r <= 8'd0;
      ser_bit_r    <= 1'b0;
      ser_valid_r  <= 1'b0;
      ser_first_r  <= 1'b0;
      ser_last_r   <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      shreg_r      <= shreg_s;
      cnt_r        <= cnt_s;
      gcnt_r       <= gcnt_s;
      hold_r       <= hold_s;
      hold_full_r  <= hold_full_s;
      words_sent_r <= words_sent_s;
      ser_bit_r    <= ser_bit_s;
      ser_valid_r  <= ser_valid_s;
      ser_first_r  <= ser_first_s;
      ser_last_r   <= ser_last_s;
      busy_r       <= busy_s;
    end
  end

  assign ser_bit    = ser_bit_r;
  assign ser_valid  = ser_valid_r;
  assign ser_first  = ser_first_r;
  assign ser_last   = ser_last_r;
  assign busy       = busy_r;
  assign words_sent = words_sent_r;

endmodule

// File: tb/tb_word_serializer.sv
// Scoreboard bench for word_serializer: a GAP=0 instance for framing, hold, reset
// and wrap behaviour, and a GAP=3 instance for inter-word spacing.
`timescale 1ns/1ps
module tb_word_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] d0_data, g_data;
  logic       d0_valid, g_valid;
  logic       d0_ready, d0_bit, d0_sv, d0_first, d0_last, d0_busy;
  logic       g_ready, g_bit, g_sv, g_first, g_last, g_busy;
  logic [7:0] d0_ws, g_ws;

  word_serializer #(.WIDTH(8), .GAP(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(d0_data), .in_valid(d0_valid),
    .in_ready(d0_ready), .ser_bit(d0_bit), .ser_valid(d0_sv),
    .ser_first(d0_first), .ser_last(d0_last), .busy(d0_busy), .words_sent(d0_ws)
  );

  word_serializer #(.WIDTH(8), .GAP(3)) dut_gap (
    .clk(clk), .rst_n(rst_n), .in_data(g_data), .in_valid(g_valid),
    .in_ready(g_ready), .ser_bit(g_bit), .ser_valid(g_sv),
    .ser_first(g_first), .ser_last(g_last), .busy(g_busy), .words_sent(g_ws)
  );

  int n_vec = 0;
  int n_bad = 0;
  logic [2:0] q0[$];
  logic [2:0] qg[$];
  logic clr_stats = 1'b0;
  int run_len, max_run, lasts0, gap_len, gap_checks;
  bit seen_last_g;
  logic [2:0] e0, eg;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: got timeout/unexpected expected normal completion", name);
  endtask

  // Words in flight are discarded by reset, so their expectations go too.
  always @(posedge clk) begin
    if (!rst_n) begin
      q0.delete();
      qg.delete();
    end
  end

  // Monitor: pop expected {bit,first,last} for every valid bit, track run/gap lengths.
  always @(negedge clk) begin
    if (clr_stats) begin
      run_len = 0; max_run = 0; lasts0 = 0;
      seen_last_g = 1'b0; gap_len = 0; gap_checks = 0;
    end else if (rst_n) begin
      if (d0_sv) begin
        if (q0.size() == 0) fail_now("dut0 unexpected bit");
        else begin
          e0 = q0.pop_front();
          check("dut0 bit/first/last", 32'({d0_bit, d0_first, d0_last}), 32'(e0));
        end
        run_len++;
        if (run_len > max_run) max_run = run_len;
        if (d0_last) lasts0++;
      end else begin
        check("dut0 idle strobes", 32'({d0_bit, d0_first, d0_last}), 32'd0);
        run_len = 0;
      end
      if (g_sv) begin
        if (qg.size() == 0) fail_now("gap unexpected bit");
        else begin
          eg = qg.pop_front();
          check("gap bit/first/last", 32'({g_bit, g_first, g_last}), 32'(eg));
        end
        if (g_first && seen_last_g) begin
          check("gap idle cycles", 32'(gap_len), 32'd3);
          gap_checks++;
        end
        seen_last_g = g_last;
        gap_len = 0;
      end else begin
        check("gap idle strobes", 32'({g_bit, g_first, g_last}), 32'd0);
        if (seen_last_g) gap_len++;
      end
    end
  end

  // Present a word and hold it until accepted; expectations are queued at acceptance.
  task automatic send(input bit sel, input logic [7:0] w, output int waits);
    bit rdy, done;
    logic [2:0] e;
    waits = 0;
    done  = 1'b0;
    if (sel) begin g_data = w; g_valid = 1'b1; end
    else begin d0_data = w; d0_valid = 1'b1; end
    for (int i = 0; i < 64 && !done; i++) begin
      rdy = sel ? g_ready : d0_ready;
      @(posedge clk);
      if (rdy) begin
        done = 1'b1;
        for (int b = 7; b >= 0; b--) begin
          e = {w[b], (b == 7), (b == 0)};
          if (sel) qg.push_back(e);
          else q0.push_back(e);
        end
      end else begin
        waits++;
      end
      @(negedge clk);
    end
    if (!done) fail_now("accept timeout");
  endtask

  task automatic wait_idle(input bit sel);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (sel) done = !g_busy && !g_sv;
      else done = !d0_busy && !d0_sv;
    end
    if (!done) fail_now("idle timeout");
  endtask

  task automatic clear_stats();
    @(posedge clk);
    clr_stats = 1'b1;
    @(posedge clk);
    clr_stats = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  int w;

  initial begin
    rst_n = 1'b0;
    d0_data = 8'd0; d0_valid = 1'b0;
    g_data = 8'd0;  g_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("reset ser_valid", 32'(d0_sv), 32'd0);
    check("reset busy", 32'({d0_busy, g_busy}), 32'd0);
    check("reset in_ready", 32'({d0_ready, g_ready}), 32'd0);
    check("reset words_sent", 32'(d0_ws), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready after reset", 32'(d0_ready), 32'd1);
    clear_stats();

    // Single word 0x0A: MSB in the cycle after acceptance, then idle.
    send(1'b0, 8'h0A, w);
    check("latency first bit", 32'({d0_sv, d0_first}), 32'd3);
    d0_valid = 1'b0;
    d0_data  = 8'h5A;
    wait_idle(1'b0);
    check("words_sent single", 32'(d0_ws), 32'd1);
    check("busy after single", 32'(d0_busy), 32'd0);

    // Three back-to-back words must stream without a bubble.
    clear_stats();
    send(1'b0, 8'hFF, w);
    send(1'b0, 8'h05, w);
    send(1'b0, 8'h80, w);
    d0_valid = 1'b0;
    wait_idle(1'b0);
    check("continuous run length", 32'(max_run), 32'd24);
    check("words_sent continuous", 32'(d0_ws), 32'd4);

    // Second word lands in hold at cnt=2; third stalls until hold drains.
    send(1'b0, 8'h3C, w);
    d0_valid = 1'b0;
    repeat (2) @(negedge clk);
    send(1'b0, 8'hC3, w);
    check("hold accept waits", 32'(w), 32'd0);
    check("in_ready while hold full", 32'({d0_ready, d0_busy}), 32'd1);
    send(1'b0, 8'h96, w);
    check("stalled word waits", 32'(w), 32'd5);
    d0_valid = 1'b0;
    wait_idle(1'b0);
    check("words_sent hold path", 32'(d0_ws), 32'd7);

    // Reset during cnt=4 with hold full discards both words.
    pulse_reset();
    send(1'b0, 8'h5B, w);
    send(1'b0, 8'h6D, w);
    d0_valid = 1'b0;
    check("hold full before reset", 32'(d0_ready), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("mid-word reset ser_valid", 32'(d0_sv), 32'd0);
    check("mid-word reset busy", 32'(d0_busy), 32'd0);
    check("mid-word reset words_sent", 32'(d0_ws), 32'd0);
    check("mid-word reset in_ready", 32'(d0_ready), 32'd1);
    send(1'b0, 8'hE7, w);
    d0_valid = 1'b0;
    wait_idle(1'b0);
    check("words_sent after reset word", 32'(d0_ws), 32'd1);

    // 256 words wrap the completed-word counter back to zero.
    pulse_reset();
    clear_stats();
    for (int i = 0; i < 256; i++) send(1'b0, 8'(i) ^ 8'h3C, w);
    d0_valid = 1'b0;
    wait_idle(1'b0);
    check("words_sent wrap", 32'(d0_ws), 32'd0);
    check("ser_last count", 32'(lasts0), 32'd256);

    // GAP=3 instance: three idle cycles between consecutive words.
    clear_stats();
    send(1'b1, 8'h01, w);
    send(1'b1, 8'h02, w);
    g_valid = 1'b0;
    wait_idle(1'b1);
    check("gap measured once", 32'(gap_checks), 32'd1);
    check("gap words_sent", 32'(g_ws), 32'd2);

    check("dut0 leftover expectations", 32'(q0.size()), 32'd0);
    check("gap leftover expectations", 32'(qg.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
